mult_arbiter_192: RTL and testbench

- Shares one 192-bit modular multiplier among NUM_REQ requesters, e.g. point-add and point-double sequencers in the ECDH core.
- Arbitrates round-robin and latches the winner's operands.
- Holds the operands stable on the multiplier inputs for the whole computation, issues the one-cycle start pulse, and waits for the result-valid pulse.
- Routes the reduced product back to the winner, with a watchdog for a multiplier that never answers.

---
 rtl/ecdh_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 38 +++
 rtl/mult_arbiter_192.sv | 188 ++++++++++++++++++
 tb/tb_mult_arbiter_192.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecdh_pkg.sv
// Shared constants and FSM encoding for the ECDH arithmetic blocks.
package ecdh_pkg;

  // Field element width for the 192-bit curve.
  localparam int BW_GF = 192;

  // Default number of BUSY cycles before a silent multiplier is abandoned.
  localparam int TIMEOUT_DEFAULT = 64;

  // Multiplier-arbiter control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at rr_ptr and wraps at NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW      = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx
);

  logic          found_s;
  logic [IW:0]   idx_s;

  // First requester at or after rr_ptr, in wrapping order, wins.
  always_comb begin
    grant     = {NUM_REQ{1'b0}};
    grant_idx = {IW{1'b0}};
    found_s   = 1'b0;
    idx_s     = {(IW+1){1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s = {1'b0, rr_ptr} + (IW+1)'(k);
      if (idx_s >= (IW+1)'(NUM_REQ)) begin
        idx_s = idx_s - (IW+1)'(NUM_REQ);
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && req[idx_s[IW-1:0]]) begin
        found_s                 = 1'b1;
        grant[idx_s[IW-1:0]]    = 1'b1;
        grant_idx               = idx_s[IW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter_192.sv
// Shares one modular multiplier among NUM_REQ requesters: round-robin grant,
// operand latch, start pulse, result routing and a watchdog for a silent multiplier.
module mult_arbiter_192 #(
  parameter int BW_GF   = ecdh_pkg::BW_GF,
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = ecdh_pkg::TIMEOUT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*BW_GF-1:0] req_a,
  input  logic [NUM_REQ*BW_GF-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [BW_GF-1:0]         rsp_data,
  output logic                     rsp_err,
  output logic                     mult_start,
  output logic [BW_GF-1:0]         mult_a,
  output logic [BW_GF-1:0]         mult_b,
  input  logic [BW_GF-1:0]         mult_out,
  input  logic                     mult_valid,
  output logic                     busy,
  output logic                     err_timeout
);

  import ecdh_pkg::*;

  localparam int            IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int            WW      = $clog2(TIMEOUT) + 1;
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  arb_state_t         state_r;
  arb_state_t         state_s;
  logic [IW-1:0]      rr_ptr_r;
  logic [IW-1:0]      owner_r;
  logic [IW-1:0]      grant_idx_s;
  logic [IW-1:0]      rr_ptr_nxt_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [NUM_REQ-1:0] ready_s;
  logic [NUM_REQ-1:0] owner_oh_s;
  logic [NUM_REQ-1:0] rsp_valid_r;
  logic [WW-1:0]      wd_r;
  logic [BW_GF-1:0]   a_sel_s;
  logic [BW_GF-1:0]   b_sel_s;
  logic [BW_GF-1:0]   mult_a_r;
  logic [BW_GF-1:0]   mult_b_r;
  logic [BW_GF-1:0]   rsp_data_r;
  logic               hs_s;
  logic               done_ok_s;
  logic               done_to_s;
  logic               mult_start_r;
  logic               busy_r;
  logic               rsp_err_r;
  logic               err_timeout_r;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_arbiter (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s)
  );

  // Select the winner's operands, decode the owner and compute the next pointer.
  always_comb begin
    a_sel_s    = {BW_GF{1'b0}};
    b_sel_s    = {BW_GF{1'b0}};
    owner_oh_s = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx_s == IW'(i)) begin
        a_sel_s = req_a[i*BW_GF +: BW_GF];
        b_sel_s = req_b[i*BW_GF +: BW_GF];
      end else begin
        a_sel_s = a_sel_s;
      end
      if (owner_r == IW'(i)) begin
        owner_oh_s[i] = 1'b1;
      end else begin
        owner_oh_s[i] = 1'b0;
      end
    end
    if (grant_idx_s == IW'(NUM_REQ - 1)) begin
      rr_ptr_nxt_s = {IW{1'b0}};
    end else begin
      rr_ptr_nxt_s = grant_idx_s + IW'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state, handshake and completion decode; mult_valid beats the watchdog.
  always_comb begin
    state_s   = state_r;
    ready_s   = {NUM_REQ{1'b0}};
    hs_s      = 1'b0;
    done_ok_s = 1'b0;
    done_to_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (|grant_s) begin
          ready_s = grant_s;
          hs_s    = 1'b1;
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: state_s = BUSY;
      BUSY: begin
        if (mult_valid) begin
          done_ok_s = 1'b1;
          state_s   = RESP;
        end else if (wd_r == WD_LAST) begin
          done_to_s = 1'b1;
          state_s   = RESP;
        end else begin
          state_s = BUSY;
        end
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Operand latch, pointer/owner, watchdog, result registers and registered status.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r      <= {IW{1'b0}};
      owner_r       <= {IW{1'b0}};
      mult_a_r      <= {BW_GF{1'b0}};
      mult_b_r      <= {BW_GF{1'b0}};
      mult_start_r  <= 1'b0;
      busy_r        <= 1'b0;
      wd_r          <= {WW{1'b0}};
      rsp_valid_r   <= {NUM_REQ{1'b0}};
      rsp_data_r    <= {BW_GF{1'b0}};
      rsp_err_r     <= 1'b0;
      err_timeout_r <= 1'b0;
    end else begin
      mult_start_r <= hs_s;
      busy_r       <= (state_s != IDLE);
      if (hs_s) begin
        mult_a_r <= a_sel_s;
        mult_b_r <= b_sel_s;
        owner_r  <= grant_idx_s;
        rr_ptr_r <= rr_ptr_nxt_s;
      end
      if (state_r == START) begin
        wd_r <= {WW{1'b0}};
      end else if (state_r == BUSY) begin
        wd_r <= wd_r + WW'(1);
      end
      if (done_ok_s || done_to_s) begin
        rsp_valid_r <= owner_oh_s;
      end else begin
        rsp_valid_r <= {NUM_REQ{1'b0}};
      end
      if (done_ok_s) begin
        rsp_data_r <= mult_out;
        rsp_err_r  <= 1'b0;
      end else if (done_to_s) begin
        rsp_data_r    <= {BW_GF{1'b0}};
        rsp_err_r     <= 1'b1;
        err_timeout_r <= 1'b1;
      end
    end
  end

  assign req_ready   = ready_s;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_data    = rsp_data_r;
  assign rsp_err     = rsp_err_r;
  assign mult_start  = mult_start_r;
  assign mult_a      = mult_a_r;
  assign mult_b      = mult_b_r;
  assign busy        = busy_r;
  assign err_timeout = err_timeout_r;

endmodule

// File: tb/tb_mult_arbiter_192.sv
// Bench for mult_arbiter_192: stub multiplier with programmable latency, a cycle
// model of the arbiter feeding a response scoreboard, and directed scenarios.
module tb_mult_arbiter_192;

  localparam int W  = 192;
  localparam int N  = 2;
  localparam int TO = 64;

  typedef struct {
    int         cyc;
    int         own;
    logic [W-1:0] data;
    logic       err;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_ready, rsp_valid;
  logic [W-1:0]   rsp_data, mult_a, mult_b, mult_out;
  logic           rsp_err, mult_start, mult_valid, busy, err_timeout;

  // stub multiplier and injection
  logic         stub_valid = 1'b0, inj_valid = 1'b0, stub_active = 1'b0;
  logic [W-1:0] stub_out = '0, stub_prod = '0, inj_data = '0;
  int           stub_cnt = 0;
  int           lat_cfg = 15;
  logic         never_cfg = 1'b0;

  // counters and model state
  int           vectors = 0, miscompares = 0;
  int           cyc = 0, hs_cnt = 0;
  int           resp_cnt [N];
  logic         chk_en = 1'b0;
  exp_t         sb [$];
  exp_t         m_e, m_new;
  logic         m_idle = 1'b1, m_start = 1'b0, m_to = 1'b0, m_pop;
  int           m_ptr = 0, m_w, m_lat;
  logic [W-1:0] m_a = '0, m_b = '0, m_data = '0;
  logic [N-1:0] m_rv, m_rdy;

  assign mult_valid = stub_valid | inj_valid;
  assign mult_out   = inj_valid ? inj_data : stub_out;

  mult_arbiter_192 #(.BW_GF(W), .NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b), .mult_out(mult_out),
    .mult_valid(mult_valid), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (ptr + k) % N;
      if (((v >> idx) & N'(1)) != N'(0)) return idx;
    end
    return -1;
  endfunction

  // Stub multiplier: product of latched operands lat_cfg cycles after start.
  always @(posedge clk) begin
    #1;
    stub_valid = 1'b0;
    if (rst === 1'b1) begin
      stub_active = 1'b0;
    end else if (mult_start === 1'b1) begin
      stub_active = 1'b1;
      stub_cnt    = lat_cfg;
      stub_prod   = mult_a * mult_b;
    end else if (stub_active) begin
      stub_cnt = stub_cnt - 1;
      if (stub_cnt <= 0) begin
        stub_active = 1'b0;
        if (!never_cfg) begin
          stub_valid = 1'b1;
          stub_out   = stub_prod;
        end
      end
    end
  end

  // Cycle model and scoreboard, evaluated away from the active edge.
  always @(negedge clk) begin
    cyc   = cyc + 1;
    m_rv  = '0;
    m_pop = 1'b0;
    if (sb.size() > 0) begin
      if (sb[0].cyc == cyc) begin
        m_e   = sb.pop_front();
        m_pop = 1'b1;
        m_rv  = N'(1) << m_e.own;
        m_data = m_e.data;
        if (m_e.err) m_to = 1'b1;
      end
    end
    if (chk_en) begin
      check("rsp_valid", W'(rsp_valid), W'(m_rv));
      if (m_pop) check("rsp_err", W'(rsp_err), W'(m_e.err));
      check("rsp_data", rsp_data, m_data);
      check("err_timeout", W'(err_timeout), W'(m_to));
      check("busy", W'(busy), W'(!m_idle));
      check("mult_start", W'(mult_start), W'(m_start));
      check("mult_a", mult_a, m_a);
      check("mult_b", mult_b, m_b);
    end
    m_w   = m_idle ? pick(req_valid, m_ptr) : -1;
    m_rdy = (m_w >= 0) ? (N'(1) << m_w) : '0;
    if (chk_en) check("req_ready", W'(req_ready), W'(m_rdy));
    for (int i = 0; i < N; i++) if (rsp_valid[i] === 1'b1) resp_cnt[i]++;
    m_start = 1'b0;
    if (rst === 1'b1) begin
      sb.delete();
      m_idle = 1'b1; m_ptr = 0; m_a = '0; m_b = '0; m_data = '0; m_to = 1'b0;
    end else begin
      if (m_pop) m_idle = 1'b1;
      if (m_w >= 0) begin
        m_idle   = 1'b0;
        m_start  = 1'b1;
        m_a      = req_a[m_w*W +: W];
        m_b      = req_b[m_w*W +: W];
        m_ptr    = (m_w + 1) % N;
        m_lat    = (never_cfg || lat_cfg > TO) ? TO : lat_cfg;
        m_new.cyc = cyc + 2 + m_lat;
        m_new.own = m_w;
        m_new.err = never_cfg || (lat_cfg > TO);
        m_new.data = m_new.err ? '0 : m_a * m_b;
        sb.push_back(m_new);
        hs_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(m_idle && sb.size() == 0) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed still busy, expected idle within 400 cycles", tag);
    end
  endtask

  task automatic one_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int lat, input logic never);
    lat_cfg   = lat;
    never_cfg = never;
    req_a[r*W +: W] = a;
    req_b[r*W +: W] = b;
    req_valid = N'(1) << r;
    tick();
    // requester moves on immediately after the handshake
    req_valid = '0;
    req_a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    req_b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    int n, target, r0, r1;
    resp_cnt[0] = 0;
    resp_cnt[1] = 0;
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    repeat (2) tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // single request, 15-cycle multiplier
    one_req(0, 192'd2, 192'd3, 15, 1'b0);
    wait_idle("single0");
    one_req(1, 192'd1, 192'd9, 4, 1'b0);
    wait_idle("single1");

    // fairness with both requesters continuously valid
    r0 = resp_cnt[0];
    r1 = resp_cnt[1];
    lat_cfg = 15;
    never_cfg = 1'b0;
    req_a = {192'd11, 192'd5};
    req_b = {192'd13, 192'd7};
    req_valid = 2'b11;
    target = hs_cnt + 4;
    n = 0;
    while (hs_cnt < target && n < 500) begin
      tick();
      n++;
    end
    req_valid = '0;
    check("fair_hs_count", W'(hs_cnt), W'(target));
    wait_idle("fairness");
    check("fair_rsp0", W'(resp_cnt[0] - r0), W'(2));
    check("fair_rsp1", W'(resp_cnt[1] - r1), W'(2));

    // operand stability: operands scrambled and valid dropped after the handshake
    one_req(0, 192'd9, 192'd4, 20, 1'b0);
    wait_idle("stability");

    // timeout: multiplier never answers
    one_req(1, 192'd3, 192'd3, 10, 1'b1);
    wait_idle("timeout");
    // next request served normally, sticky flag stays
    one_req(0, 192'd6, 192'd7, 3, 1'b0);
    wait_idle("after_timeout");

    // mult_valid on the watchdog expiry cycle wins
    one_req(1, 192'd21, 192'd23, TO, 1'b0);
    wait_idle("simultaneous");

    // spurious mult_valid in IDLE
    inj_data  = {6{32'hdeadbeef}};
    inj_valid = 1'b1;
    tick();
    inj_valid = 1'b0;
    repeat (3) tick();

    // answer one cycle too late: timeout, then a late valid outside BUSY
    one_req(0, 192'd2, 192'd5, TO + 1, 1'b0);
    wait_idle("late_valid");

    // reset five cycles into BUSY
    one_req(0, 192'd17, 192'd19, 15, 1'b0);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_busy", W'(busy), W'(0));
    check("rst_mult_a", mult_a, '0);
    check("rst_err_timeout", W'(err_timeout), W'(0));
    check("rst_rsp_valid", W'(rsp_valid), W'(0));
    lat_cfg = 5;
    req_a = {192'd8, 192'd3};
    req_b = {192'd8, 192'd4};
    req_valid = 2'b11;
    #1;
    check("rst_tie_ready", W'(req_ready), W'(2'b01));
    tick();
    req_valid = '0;
    wait_idle("after_reset");
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
